// File: rtl/vedic_pkg.sv
// Shared definitions for the sequential 16x16 vedic multiplier controller.
// Holds the FSM state encoding, the step-counter width and the operand and
// product widths. The controller and its testbench both import it.
package vedic_pkg;
    localparam int OPW   = 16;  // operand width
    localparam int HALFW = 8;   // width of one operand half fed to the 8x8 core
    localparam int PRW   = 32;  // product width
    localparam int STEPW = 2;   // four partial-product steps

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage : vedic_pkg

// File: rtl/vedic_8bit_multiplier.sv
// 8x8 unsigned combinational multiplier using the Urdhva-Tiryakbhyam
// (vertically and crosswise) method.
//   a, b : 8-bit unsigned operands
//   p    : 16-bit unsigned product
// Each output column k is the sum of all bit products a[i]&b[j] with i+j==k.
// The column sums are weighted by 2^k and summed, which carries naturally
// from one column into the next.
module vedic_8bit_multiplier (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    logic [15:0] col [15];

    always_comb begin
        for (int k = 0; k < 15; k++) begin
            col[k] = '0;
            for (int i = 0; i < 8; i++) begin
                if (k - i >= 0 && k - i < 8)
                    col[k] = col[k] + 16'(a[i] & b[k-i]);
            end
        end
    end

    always_comb begin
        p = '0;
        for (int k = 0; k < 15; k++)
            p = p + (col[k] << k);
    end
endmodule : vedic_8bit_multiplier

// File: rtl/vedic_seq16_mult_ctrl.sv
// Sequential 16x16 unsigned multiplier. A single 8x8 vedic core is shared
// across four cycles. Each cycle it produces one partial product, which is
// shifted and added into a 32-bit accumulator.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b captured on accept)
//   a, b                : 16-bit unsigned operands
//   out_valid/out_ready : product handshake
//   p                   : 32-bit product, driven straight from the accumulator
//   busy                : high in any state other than IDLE
//   op_count            : wrapping count of delivered products
module vedic_seq16_mult_ctrl
    import vedic_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [PRW-1:0] p,
    output logic           busy,
    output logic [7:0]     op_count
);
    state_t             state_q, state_d;
    logic [STEPW-1:0]   step_q;
    logic [OPW-1:0]     a_q, b_q;
    logic [PRW-1:0]     acc_q;
    logic [7:0]         cnt_q;

    logic               accept, hshk;
    logic [HALFW-1:0]   mx_a, mx_b;
    logic [2*HALFW-1:0] pp;
    logic [4:0]         shamt;
    logic [PRW-1:0]     pp_sh;

    assign accept = in_valid & in_ready;
    assign hshk   = out_valid & out_ready;

    // step bit 0 selects the high half of a, step bit 1 the high half of b.
    // The shift is 8 per high half used: 0, 8, 8, 16.
    assign mx_a  = step_q[0] ? a_q[OPW-1:HALFW] : a_q[HALFW-1:0];
    assign mx_b  = step_q[1] ? b_q[OPW-1:HALFW] : b_q[HALFW-1:0];
    assign shamt = {step_q[1] & step_q[0], step_q[1] ^ step_q[0], 3'b000};
    assign pp_sh = {{(PRW-2*HALFW){1'b0}}, pp} << shamt;

    vedic_8bit_multiplier u_core (
        .a (mx_a),
        .b (mx_b),
        .p (pp)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MUL;
            MUL:     if (step_q == 2'd3) state_d = DONE;
            DONE:    if (hshk) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state alone, so there is no comb path from
    // in_valid to out_valid.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    // Datapath: operand capture, step counter, accumulator, product counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                a_q    <= a;
                b_q    <= b;
                acc_q  <= '0;
                step_q <= '0;
            end else if (state_q == MUL) begin
                acc_q  <= acc_q + pp_sh;
                step_q <= step_q + 2'd1;  // returns to 0 after step 3
            end
            if (hshk) cnt_q <= cnt_q + 8'd1;
        end
    end

    assign p        = acc_q;
    assign op_count = cnt_q;
endmodule : vedic_seq16_mult_ctrl

// File: tb/tb_vedic_seq16_mult_ctrl.sv
// Directed testbench for vedic_seq16_mult_ctrl. All stimulus changes on the
// falling edge and all outputs are sampled on the falling edge.
module tb_vedic_seq16_mult_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] p;
    logic        busy;
    logic [7:0]  op_count;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_cnt = '0;

    always #5 clk = ~clk;

    vedic_seq16_mult_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy),
        .op_count  (op_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one product. It must be called at a falling edge and it returns at
    // the falling edge right after the output handshake. exp_p is the
    // hand-computed product. stall is the number of out_valid cycles held
    // with out_ready low. scramble drives junk onto a, b and in_valid while
    // the controller is busy.
    task automatic op(input string tag, input logic [15:0] x, input logic [15:0] y,
                      input logic [31:0] exp_p, input int stall, input bit scramble);
        int lat;
        logic [31:0] held;
        a = x; b = y; in_valid = 1'b1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            if (scramble) begin
                a = 16'($urandom); b = 16'($urandom); in_valid = 1'b1;
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, ".latency"}, 32'(lat), 32'd5);
        chk({tag, ".p"}, p, exp_p);
        held = p;
        for (int i = 0; i < stall; i++) begin
            a = 16'hDEAD; b = 16'hBEEF; in_valid = 1'b1;
            @(negedge clk);
            chk({tag, ".hold_p"}, p, held);
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        chk({tag, ".released"}, 32'(out_valid), 32'd0);
        chk({tag, ".op_count"}, 32'(op_count), 32'(exp_cnt));
    endtask

    initial begin
        logic [15:0] x, y;

        // Reset state while rst_n is held low
        @(negedge clk);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.p", p, 32'd0);
        chk("rst.op_count", 32'(op_count), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel.in_ready", 32'(in_ready), 32'd1);
        chk("rel.out_valid", 32'(out_valid), 32'd0);
        chk("rel.p", p, 32'd0);

        op("basic", 16'h1234, 16'h5678, 32'h0626_0060, 0, 1'b0);
        op("max", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0, 1'b0);
        op("zero", 16'h0000, 16'hBEEF, 32'h0000_0000, 0, 1'b0);
        op("stall", 16'h00FF, 16'h00FF, 32'h0000_FE01, 3, 1'b0);
        op("scramble", 16'h00FF, 16'h0100, 32'h0000_FF00, 0, 1'b1);

        // Reset pulse in the middle of a product, during MUL step 2
        a = 16'h4321; b = 16'h8765; in_valid = 1'b1;
        @(negedge clk);               // MUL step 0
        in_valid = 1'b0;
        @(negedge clk);               // MUL step 1
        @(negedge clk);               // MUL step 2
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.op_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
        @(negedge clk);
        chk("midrst.in_ready", 32'(in_ready), 32'd1);
        chk("midrst.out_valid_after", 32'(out_valid), 32'd0);
        chk("midrst.op_count_after", 32'(op_count), 32'd0);

        // 256 back-to-back products; the counter must return to zero
        for (int n = 0; n < 256; n++) begin
            x = 16'($urandom); y = 16'($urandom);
            if (n == 0) begin x = 16'hFFFF; y = 16'h0001; end
            if (n == 1) begin x = 16'h8000; y = 16'h8000; end
            op("b2b", x, y, 32'(x) * 32'(y), 0, 1'b0);
        end
        chk("wrap.op_count", 32'(op_count), 32'd0);

        op("post", 16'h1234, 16'h5678, 32'h0626_0060, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule : tb_vedic_seq16_mult_ctrl

// File: doc/vedic_seq16_mult_ctrl.md
VEDIC_SEQ16_MULT_CTRL -- requirements
Module: vedic_seq16_mult_ctrl

Interface
REQ-001 SHALL have parameter none; all widths fixed (16-bit operands, 32-bit product).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair a/b valid.
REQ-005 SHALL have port in_ready  output  1  controller can accept operands.
REQ-006 SHALL have port a  input  16  multiplicand, unsigned.
REQ-007 SHALL have port b  input  16  multiplier, unsigned.
REQ-008 SHALL have port out_valid  output  1  product p valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts p.
REQ-010 SHALL have port p  output  32  unsigned product a*b.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port op_count  output  8  completed-product counter.

Function
REQ-013 SHALL compute a 16x16 product by time-sharing one 8x8 vedic multiplier over four partial-product steps.
REQ-014 SHALL implement FSM states IDLE, MUL, DONE; IDLE->MUL on in_valid&&in_ready; MUL->DONE after step 3; DONE->IDLE on out_valid&&out_ready.
REQ-015 SHALL drive in_ready=1 only in IDLE; no operand is accepted in MUL or DONE.
REQ-016 SHALL capture a and b into internal registers on the accept edge and clear the 32-bit accumulator to 0 on that edge.
REQ-017 SHALL use a 2-bit step counter, 0 on entry to MUL, incrementing each MUL cycle.
REQ-018 SHALL select multiplier inputs per step: 0 a[7:0]*b[7:0] shift 0; 1 a[15:8]*b[7:0] shift 8; 2 a[7:0]*b[15:8] shift 8; 3 a[15:8]*b[15:8] shift 16.
REQ-019 SHALL add the shifted 16-bit partial product into the accumulator each MUL cycle; 32-bit add with no overflow possible.
REQ-020 SHALL assert out_valid starting the cycle after the step-3 edge, i.e. exactly 5 cycles after the accept edge (4 MUL cycles + register).
REQ-021 SHALL hold p and out_valid stable while out_valid&&!out_ready (backpressure of any length).
REQ-022 SHALL drive p from the accumulator register; p value outside DONE is don't-care but SHALL be 0 after reset.
REQ-023 SHALL increment op_count by 1 on each out_valid&&out_ready handshake, wrapping 255->0.
REQ-024 SHALL ignore a, b and in_valid changes while not in IDLE; captured operands are unaffected.
REQ-025 SHALL give minimum throughput of one product per 6 cycles (accept, 4 MUL, DONE handshake; IDLE re-entry next cycle).

Reset
REQ-026 SHALL on rst_n=0, asynchronously: state=IDLE, step=0, accumulator=0, operand regs=0, op_count=0.
REQ-027 SHALL during reset and first cycle after: in_ready=1 (after release), out_valid=0, busy=0, p=0.
REQ-028 SHALL abandon any in-flight operation on reset mid-MUL or mid-DONE with no output produced and op_count unchanged from 0.

Structure
REQ-029 SHALL place state enum (IDLE, MUL, DONE), step width, operand width 16 and product width 32 in shared package vedic_pkg.
REQ-030 SHALL instantiate exactly one existing vedic_8bit_multiplier as the sole sub-module; no other multipliers.
REQ-031 SHALL keep the accumulator and shift/add logic in this module; no combinational path from in_valid to out_valid.

Verification
REQ-032 SHALL cover: a=0x1234, b=0x5678, out_ready=1 -> p=0x06260060, out_valid 5 cycles after accept, op_count 0->1.
REQ-033 SHALL cover: a=0xFFFF, b=0xFFFF -> p=0xFFFE0001; a=0x0000, b=0xBEEF -> p=0x00000000.
REQ-034 SHALL cover: out_ready low 3 cycles after out_valid -> p stable, in_ready=0, new in_valid ignored; product released on 4th cycle.
REQ-035 SHALL cover: rst_n pulsed low at MUL step 2 -> out_valid=0, in_ready=1 after release, op_count=0, next op correct.
REQ-036 SHALL cover: a/b changed every cycle during MUL for a=0x00FF, b=0x0100 -> p=0x0000FF00.
REQ-037 SHALL cover: 256 back-to-back products -> op_count wraps to 0, all products match reference model.
